// File: rtl/sseg_mux_driver.sv
// Time-multiplexed seven-segment scanner: frame-coherent shadow capture, per-digit
// blanking, leading-zero suppression and 16-phase PWM brightness per digit slot.
module sseg_mux_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SUBDIV     = 6250,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           en,
    input  logic [4*NUM_DIGITS-1:0]        hex_in,
    input  logic [NUM_DIGITS-1:0]          dp_in,
    input  logic [NUM_DIGITS-1:0]          blank_in,
    input  logic                           lz_suppress,
    input  logic [3:0]                     bright,
    output logic [NUM_DIGITS-1:0]          an,
    output logic [7:0]                     sseg,
    output logic [$clog2(NUM_DIGITS)-1:0]  digit_idx,
    output logic                           frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int SUB_W = (SUBDIV > 1) ? $clog2(SUBDIV) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(SUBDIV - 1);

    // Asserted-high segment pattern {g,f,e,d,c,b,a}; b and d are lowercase.
    function automatic logic [6:0] hex_font(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] drive_seg(input logic [7:0] s);
        return ACTIVE_LOW ? ~s : s;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] drive_an(input logic [NUM_DIGITS-1:0] a);
        return ACTIVE_LOW ? ~a : a;
    endfunction

    logic [SUB_W-1:0]        sub;
    logic [3:0]              phase;
    logic                    primed;
    logic [4*NUM_DIGITS-1:0] hex_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [NUM_DIGITS-1:0]   blank_sh;
    logic                    lz_sh;

    logic sub_tc, phase_tc, wrap, capture;

    assign sub_tc   = (sub == LAST_SUB);
    assign phase_tc = sub_tc && (phase == 4'hF);
    assign wrap     = en && phase_tc && (digit_idx == LAST_IDX);
    // The very first cycle out of reset loads the shadows so the display starts without waiting a frame.
    assign capture  = wrap || !primed;

    // Scan counters: sub -> phase -> digit slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sub        <= '0;
            phase      <= '0;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
            primed     <= 1'b0;
        end else begin
            primed     <= 1'b1;
            frame_tick <= wrap;
            if (en) begin
                sub <= sub_tc ? '0 : sub + 1'b1;
                if (sub_tc)
                    phase <= phase + 1'b1;
                if (phase_tc)
                    digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
            end
        end
    end

    // Frame shadow capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_sh   <= '0;
            dp_sh    <= '0;
            blank_sh <= '1;
            lz_sh    <= 1'b0;
        end else if (capture) begin
            hex_sh   <= hex_in;
            dp_sh    <= dp_in;
            blank_sh <= blank_in;
            lz_sh    <= lz_suppress;
        end
    end

    logic [NUM_DIGITS:0]   zero_above;
    logic [3:0]            cur_hex;
    logic                  cur_dp, cur_blank, cur_zero, suppress, dark, lit;
    logic [NUM_DIGITS-1:0] onehot;
    logic [NUM_DIGITS-1:0] an_p0;
    logic [7:0]            sseg_p0;

    // Slot decode from current counter state (p0)
    always_comb begin
        zero_above = '0;
        cur_hex    = '0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b1;
        cur_zero   = 1'b0;
        onehot     = '0;
        zero_above[NUM_DIGITS] = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--)
            zero_above[k] = zero_above[k+1] && (hex_sh[4*k +: 4] == 4'h0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IDX_W'(k) == digit_idx) begin
                cur_hex   = hex_sh[4*k +: 4];
                cur_dp    = dp_sh[k];
                cur_blank = blank_sh[k];
                cur_zero  = zero_above[k];
                onehot[k] = 1'b1;
            end
        end
        suppress = lz_sh && (digit_idx != '0) && cur_zero;
        dark     = cur_blank || (suppress && !cur_dp);
        lit      = en && !dark && (phase <= bright);
        an_p0    = lit ? onehot : '0;
        sseg_p0  = lit ? {cur_dp, (suppress ? 7'h00 : hex_font(cur_hex))} : 8'h00;
    end

    // Output register (p1): pins reflect counter state one clock later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an   <= drive_an('0);
            sseg <= drive_seg(8'h00);
        end else begin
            an   <= drive_an(an_p0);
            sseg <= drive_seg(sseg_p0);
        end
    end

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Directed bench for sseg_mux_driver with NUM_DIGITS=4, SUBDIV=2 (32 clk/slot, 128 clk/frame).
module tb_sseg_mux_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [15:0] hex_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_suppress;
    logic [3:0]  bright;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] an_log [128];
    logic [7:0] ss_log [128];
    logic       ft_log [128];

    always #5 clk = ~clk;

    sseg_mux_driver #(.NUM_DIGITS(4), .SUBDIV(2), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .hex_in(hex_in), .dp_in(dp_in),
        .blank_in(blank_in), .lz_suppress(lz_suppress), .bright(bright),
        .an(an), .sseg(sseg), .digit_idx(digit_idx), .frame_tick(frame_tick)
    );

    function automatic logic [3:0] slot_an(input int k);
        return 4'b1111 ^ (4'b0001 << k);
    endfunction

    // Returns at the negedge where frame_tick is seen (digit_idx has just wrapped).
    task automatic sync_frame(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic capture_frame;
        for (int n = 0; n < 128; n++) begin
            @(negedge clk);
            an_log[n] = an;
            ss_log[n] = sseg;
            ft_log[n] = frame_tick;
        end
    endtask

    task automatic test_reset;
        int c;
        reset_n = 1'b0; en = 1'b1; hex_in = 16'h1234; dp_in = 4'h0; blank_in = 4'h0;
        lz_suppress = 1'b0; bright = 4'd15;
        repeat (3) @(negedge clk);
        n_tests++; if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b required 1111", an); end
        n_tests++; if (sseg !== 8'hFF) begin n_fail++; $display("FAIL reset_sseg: got %h required ff", sseg); end
        n_tests++; if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d required 0", digit_idx); end
        n_tests++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b required 0", frame_tick); end
        reset_n = 1'b1;
        c = 0;
        while (an === 4'b1111 && c < 40) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (an !== 4'b1110 || sseg !== 8'h99 || digit_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_first_slot: an=%b sseg=%h idx=%0d required an=1110 sseg=99 idx=0", an, sseg, digit_idx);
        end
    endtask

    task automatic test_digits;
        bit ok;
        int bad;
        logic [7:0] es [4];
        es = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        sync_frame(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL digits_sync: frame_tick=0 for 300 clk, required a pulse"); end
        capture_frame();
        for (int k = 0; k < 4; k++) begin
            bad = 0;
            for (int i = 0; i < 32; i++)
                if (an_log[32*k+i] !== slot_an(k) || ss_log[32*k+i] !== es[k]) bad++;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL digits_slot%0d: %0d cycles differ (an=%b sseg=%h at start) required an=%b sseg=%h",
                         k, bad, an_log[32*k], ss_log[32*k], slot_an(k), es[k]);
            end
        end
        bad = 0;
        for (int n = 0; n < 128; n++)
            if (ft_log[n] !== (n == 127)) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL frame_period: %0d cycles with wrong frame_tick, required single pulse 128 clk after previous", bad);
        end
    endtask

    task automatic test_lz;
        bit ok;
        int bad;
        logic [3:0] ea [4];
        logic [7:0] es [4];
        for (int pass = 0; pass < 3; pass++) begin
            lz_suppress = 1'b1;
            case (pass)
                0: begin hex_in = 16'h0050; dp_in = 4'b0000;
                         ea = '{4'b1110, 4'b1101, 4'b1111, 4'b1111}; es = '{8'hC0, 8'h92, 8'hFF, 8'hFF}; end
                1: begin hex_in = 16'h0000; dp_in = 4'b0000;
                         ea = '{4'b1110, 4'b1111, 4'b1111, 4'b1111}; es = '{8'hC0, 8'hFF, 8'hFF, 8'hFF}; end
                default: begin hex_in = 16'h0050; dp_in = 4'b0100;
                         ea = '{4'b1110, 4'b1101, 4'b1011, 4'b1111}; es = '{8'hC0, 8'h92, 8'h7F, 8'hFF}; end
            endcase
            sync_frame(ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL lz_sync%0d: frame_tick=0 for 300 clk, required a pulse", pass); end
            capture_frame();
            for (int k = 0; k < 4; k++) begin
                bad = 0;
                for (int i = 0; i < 32; i++)
                    if (an_log[32*k+i] !== ea[k] || ss_log[32*k+i] !== es[k]) bad++;
                n_tests++;
                if (bad != 0) begin
                    n_fail++;
                    $display("FAIL lz%0d_slot%0d: %0d cycles differ (an=%b sseg=%h at start) required an=%b sseg=%h",
                             pass, k, bad, an_log[32*k], ss_log[32*k], ea[k], es[k]);
                end
            end
        end
        lz_suppress = 1'b0; dp_in = 4'b0000;
    endtask

    task automatic test_blank;
        bit ok;
        int bad;
        logic [3:0] ea [4];
        logic [7:0] es [4];
        ea = '{4'b1110, 4'b1111, 4'b1011, 4'b0111};
        es = '{8'h99, 8'hFF, 8'hA4, 8'hF9};
        hex_in = 16'h1234; dp_in = 4'b0010; blank_in = 4'b0010; lz_suppress = 1'b0;
        sync_frame(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL blank_sync: frame_tick=0 for 300 clk, required a pulse"); end
        capture_frame();
        bad = 0;
        for (int n = 0; n < 128; n++)
            if (an_log[n] !== ea[n/32] || ss_log[n] !== es[n/32]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL blank_digit1: %0d cycles differ (slot1 an=%b sseg=%h) required an=1111 sseg=ff", bad, an_log[40], ss_log[40]);
        end
        dp_in = 4'b0000; blank_in = 4'b0000;
    endtask

    task automatic test_bright;
        bit ok;
        int bad, lit0;
        logic [3:0] ea;
        logic [7:0] ev;
        logic [7:0] es [4];
        logic [3:0] lvl [2];
        es = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        lvl = '{4'd3, 4'd0};
        for (int p = 0; p < 2; p++) begin
            bright = lvl[p];
            sync_frame(ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL bright_sync%0d: frame_tick=0 for 300 clk, required a pulse", p); end
            capture_frame();
            bad = 0; lit0 = 0;
            for (int n = 0; n < 128; n++) begin
                ea = (((n % 32) / 2) <= int'(lvl[p])) ? slot_an(n / 32) : 4'b1111;
                ev = (ea == 4'b1111) ? 8'hFF : es[n/32];
                if (an_log[n] !== ea || ss_log[n] !== ev) bad++;
                if (n < 32 && an_log[n] !== 4'b1111) lit0++;
            end
            n_tests++;
            if (bad != 0) begin n_fail++; $display("FAIL bright%0d_pattern: %0d cycles differ from phase<=bright duty", lvl[p], bad); end
            n_tests++;
            if (lit0 != 2 * (int'(lvl[p]) + 1)) begin
                n_fail++; $display("FAIL bright%0d_lit: slot0 lit %0d clk, required %0d", lvl[p], lit0, 2 * (int'(lvl[p]) + 1));
            end
        end
        bright = 4'd15;
    endtask

    task automatic test_mid_frame;
        bit ok;
        hex_in = 16'h1234;
        sync_frame(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL mid_sync: frame_tick=0 for 300 clk, required a pulse"); end
        repeat (40) @(negedge clk);
        hex_in = 16'h5678;
        repeat (48) @(negedge clk);
        n_tests++;
        if (an !== 4'b1011 || sseg !== 8'hA4) begin
            n_fail++; $display("FAIL mid_hold: an=%b sseg=%h required an=1011 sseg=a4", an, sseg);
        end
        sync_frame(ok);
        capture_frame();
        n_tests++;
        if (ss_log[5] !== 8'h80 || ss_log[37] !== 8'hF8) begin
            n_fail++; $display("FAIL mid_next_frame: slot0 %h slot1 %h required 80 f8", ss_log[5], ss_log[37]);
        end
        n_tests++;
        if (ss_log[70] !== 8'h82 || ss_log[100] !== 8'h92) begin
            n_fail++; $display("FAIL mid_next_frame_hi: slot2 %h slot3 %h required 82 92", ss_log[70], ss_log[100]);
        end
        hex_in = 16'h1234;
    endtask

    task automatic test_enable;
        bit ok;
        int bad, c;
        sync_frame(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL en_sync: frame_tick=0 for 300 clk, required a pulse"); end
        repeat (45) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        n_tests++;
        if (an !== 4'b1111 || sseg !== 8'hFF || digit_idx !== 2'd1) begin
            n_fail++; $display("FAIL en_off: an=%b sseg=%h idx=%0d required 1111 ff 1", an, sseg, digit_idx);
        end
        bad = 0;
        repeat (49) begin
            @(negedge clk);
            if (an !== 4'b1111 || sseg !== 8'hFF || digit_idx !== 2'd1 || frame_tick !== 1'b0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL en_frozen: %0d cycles not dark/frozen at idx 1", bad); end
        en = 1'b1;
        @(negedge clk);
        n_tests++;
        if (an !== 4'b1101 || sseg !== 8'hB0) begin
            n_fail++; $display("FAIL en_resume: an=%b sseg=%h required 1101 b0", an, sseg);
        end
        c = 1;
        while (c < 200) begin
            @(negedge clk);
            c++;
            if (frame_tick === 1'b1) break;
        end
        n_tests++; if (c != 83) begin n_fail++; $display("FAIL en_resume_phase: frame_tick after %0d clk required 83", c); end
        repeat (127) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        n_tests++;
        if (frame_tick !== 1'b0 || digit_idx !== 2'd3) begin
            n_fail++; $display("FAIL en_wrap_blocked: tick=%b idx=%0d required 0 3", frame_tick, digit_idx);
        end
        en = 1'b1;
        @(negedge clk);
        n_tests++;
        if (frame_tick !== 1'b1 || digit_idx !== 2'd0) begin
            n_fail++; $display("FAIL en_wrap_after: tick=%b idx=%0d required 1 0", frame_tick, digit_idx);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int c;
        sync_frame(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_sync: frame_tick=0 for 300 clk, required a pulse"); end
        repeat (40) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (an !== 4'b1111 || sseg !== 8'hFF || digit_idx !== 2'd0 || frame_tick !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async: an=%b sseg=%h idx=%0d tick=%b required 1111 ff 0 0", an, sseg, digit_idx, frame_tick);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        c = 0;
        while (an === 4'b1111 && c < 40) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (an !== 4'b1110 || sseg !== 8'h99) begin
            n_fail++; $display("FAIL rstmid_recover: an=%b sseg=%h required 1110 99", an, sseg);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_digits();
        test_lz();
        test_blank();
        test_bright();
        test_mid_frame();
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
